// File: rtl/pe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_pkg : shared types for the mesh processing element (ctrl word, selects)
// Revision 1.0
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam int c_ctrl_w = 11;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MUL = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    SRC_E    = 3'b000,
    SRC_S    = 3'b001,
    SRC_W    = 3'b010,
    SRC_N    = 3'b011,
    SRC_MEM  = 3'b100,
    SRC_ZERO = 3'b101,
    SRC_ONE  = 3'b110,
    SRC_ONES = 3'b111
  } src_sel_e;

  // 3'b110 and 3'b111 are unnamed and behave like DST_NONE
  typedef enum logic [2:0] {
    DST_E    = 3'b000,
    DST_S    = 3'b001,
    DST_W    = 3'b010,
    DST_N    = 3'b011,
    DST_ALL  = 3'b100,
    DST_NONE = 3'b101
  } dst_sel_e;

  typedef struct packed {
    dst_sel_e out_sel;
    src_sel_e op1_sel;
    src_sel_e op2_sel;
    opcode_e  opcode;
  } pe_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pe_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_alu : combinational add/sub/and/mul, all results modulo 2^DW
// Revision 1.0
// ----------------------------------------------------------------------------
module pe_alu
  import pe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  opcode_e       opcode,
  output logic [DW-1:0] y
);

  // DW-wide result context drops carry, borrow and the product's upper half
  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_MUL:  y = a * b;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe : mesh processing element - operand muxes, ALU, local result register
//      and four neighbour-facing output registers
// Revision 1.0
// ----------------------------------------------------------------------------
module pe
  import pe_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 5,
  parameter int CW = c_ctrl_w
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] ctrl,
  input  logic [DW-1:0] E,
  input  logic [DW-1:0] S,
  input  logic [DW-1:0] W,
  input  logic [DW-1:0] N,
  output logic [OW-1:0] OutputE,
  output logic [OW-1:0] OutputS,
  output logic [OW-1:0] OutputW,
  output logic [OW-1:0] OutputN,
  output logic [DW-1:0] Data_memory
);

  pe_ctrl_t      w_ctrl;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;
  logic [DW-1:0] w_result;

  logic [DW-1:0] r_data_memory;
  logic [OW-1:0] r_out_e;
  logic [OW-1:0] r_out_s;
  logic [OW-1:0] r_out_w;
  logic [OW-1:0] r_out_n;

  assign w_ctrl = pe_ctrl_t'(ctrl);

  function automatic logic [DW-1:0] pick(input src_sel_e sel,
                                         input logic [DW-1:0] e_in,
                                         input logic [DW-1:0] s_in,
                                         input logic [DW-1:0] w_in,
                                         input logic [DW-1:0] n_in,
                                         input logic [DW-1:0] mem);
    logic [DW-1:0] v;
    v = '0;
    case (sel)
      SRC_E:    v = e_in;
      SRC_S:    v = s_in;
      SRC_W:    v = w_in;
      SRC_N:    v = n_in;
      SRC_MEM:  v = mem;
      SRC_ZERO: v = '0;
      SRC_ONE:  v = DW'(1);
      SRC_ONES: v = '1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Feedback reads the registered value, so accumulation is legal every cycle
  assign w_op1 = pick(w_ctrl.op1_sel, E, S, W, N, r_data_memory);
  assign w_op2 = pick(w_ctrl.op2_sel, E, S, W, N, r_data_memory);

  pe_alu #(.DW(DW)) u_alu (
    .a      (w_op1),
    .b      (w_op2),
    .opcode (w_ctrl.opcode),
    .y      (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_memory <= '0;
      r_out_e       <= '0;
      r_out_s       <= '0;
      r_out_w       <= '0;
      r_out_n       <= '0;
    end else begin
      r_data_memory <= w_result;
      case (w_ctrl.out_sel)
        DST_E: r_out_e <= w_result[OW-1:0];
        DST_S: r_out_s <= w_result[OW-1:0];
        DST_W: r_out_w <= w_result[OW-1:0];
        DST_N: r_out_n <= w_result[OW-1:0];
        DST_ALL: begin
          r_out_e <= w_result[OW-1:0];
          r_out_s <= w_result[OW-1:0];
          r_out_w <= w_result[OW-1:0];
          r_out_n <= w_result[OW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign Data_memory = r_data_memory;
  assign OutputE     = r_out_e;
  assign OutputS     = r_out_s;
  assign OutputW     = r_out_w;
  assign OutputN     = r_out_n;

endmodule
`default_nettype wire

// File: tb/tb_pe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pe : directed vector table plus reset sequences for the pe block
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] ctrl = '0;
  logic [7:0]  E = '0, S = '0, W = '0, N = '0;
  logic [4:0]  OutputE, OutputS, OutputW, OutputN;
  logic [7:0]  Data_memory;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (ctrl),
    .E           (E),
    .S           (S),
    .W           (W),
    .N           (N),
    .OutputE     (OutputE),
    .OutputS     (OutputS),
    .OutputW     (OutputW),
    .OutputN     (OutputN),
    .Data_memory (Data_memory)
  );

  typedef struct {
    logic [10:0] ctrl;
    logic [7:0]  e, s, w, n;
    logic [7:0]  dm;
    logic [4:0]  oe, os, ow, on;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic logic [10:0] cw(input logic [2:0] o, input logic [2:0] a,
                                     input logic [2:0] b, input logic [1:0] op);
    return {o, a, b, op};
  endfunction

  function automatic vec_t mk(input logic [10:0] c, input logic [7:0] e,
                              input logic [7:0] s, input logic [7:0] w,
                              input logic [7:0] n, input logic [7:0] dm,
                              input logic [4:0] oe, input logic [4:0] os,
                              input logic [4:0] ow, input logic [4:0] on);
    vec_t v;
    v.ctrl = c; v.e = e; v.s = s; v.w = w; v.n = n;
    v.dm = dm; v.oe = oe; v.os = os; v.ow = ow; v.on = on;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %02h, expected %02h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx, input logic [7:0] dm,
                         input logic [4:0] oe, input logic [4:0] os,
                         input logic [4:0] ow, input logic [4:0] on);
    chk({name, ".dm"}, idx, Data_memory, dm);
    chk({name, ".oE"}, idx, {3'b0, OutputE}, {3'b0, oe});
    chk({name, ".oS"}, idx, {3'b0, OutputS}, {3'b0, os});
    chk({name, ".oW"}, idx, {3'b0, OutputW}, {3'b0, ow});
    chk({name, ".oN"}, idx, {3'b0, OutputN}, {3'b0, on});
  endtask

  initial begin
    // Sequential vectors: each expected value depends on state left by the previous one
    vecs[0]  = mk(cw(3'b000,3'b000,3'b001,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h76, 5'h16,5'h00,5'h00,5'h00);
    vecs[1]  = mk(cw(3'b000,3'b001,3'b010,2'b01), 8'hAA,8'hCC,8'hF0,8'h0F, 8'hDC, 5'h1C,5'h00,5'h00,5'h00);
    vecs[2]  = mk(cw(3'b001,3'b001,3'b010,2'b11), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h40, 5'h1C,5'h00,5'h00,5'h00);
    vecs[3]  = mk(cw(3'b010,3'b000,3'b110,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'hAB, 5'h1C,5'h00,5'h0B,5'h00);
    vecs[4]  = mk(cw(3'b011,3'b100,3'b111,2'b01), 8'hAA,8'hCC,8'hF0,8'h0F, 8'hAC, 5'h1C,5'h00,5'h0B,5'h0C);
    vecs[5]  = mk(cw(3'b101,3'b101,3'b011,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h0F, 5'h1C,5'h00,5'h0B,5'h0C);
    vecs[6]  = mk(cw(3'b111,3'b000,3'b000,2'b11), 8'hAA,8'hCC,8'hF0,8'h0F, 8'hE4, 5'h1C,5'h00,5'h0B,5'h0C);
    vecs[7]  = mk(cw(3'b110,3'b010,3'b001,2'b10), 8'hAA,8'hCC,8'hF0,8'h0F, 8'hC0, 5'h1C,5'h00,5'h0B,5'h0C);
    vecs[8]  = mk(cw(3'b101,3'b101,3'b101,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h00, 5'h1C,5'h00,5'h0B,5'h0C);
    vecs[9]  = mk(cw(3'b100,3'b100,3'b011,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h0F, 5'h0F,5'h0F,5'h0F,5'h0F);
    vecs[10] = mk(cw(3'b100,3'b100,3'b011,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h1E, 5'h1E,5'h1E,5'h1E,5'h1E);
    vecs[11] = mk(cw(3'b100,3'b100,3'b011,2'b00), 8'hAA,8'hCC,8'hF0,8'h0F, 8'h2D, 5'h0D,5'h0D,5'h0D,5'h0D);

    // Reset asserted between edges clears state at once and holds while low
    #3 rst_n = 1'b0;
    #1 chk_all("reset_now", 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      E = 8'h11 * 8'(i + 1); S = ~E; W = E ^ 8'h5A; N = E + 8'h3;
      ctrl = cw(3'b100, 3'b000, 3'b001, 2'(i));
      @(posedge clk); #1;
      chk_all("reset_hold", i, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ctrl = vecs[i].ctrl;
      E = vecs[i].e; S = vecs[i].s; W = vecs[i].w; N = vecs[i].n;
      @(posedge clk); #1;
      chk_all("vec", i, vecs[i].dm, vecs[i].oe, vecs[i].os, vecs[i].ow, vecs[i].on);
    end

    // Mid-run async reset, then first edge after release uses current ctrl on cleared state
    @(negedge clk);
    ctrl = cw(3'b000, 3'b100, 3'b000, 2'b00);
    E = 8'h33;
    #1 rst_n = 1'b0;
    #1 chk_all("midrun_reset", 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    @(posedge clk); #1;
    chk_all("midrun_hold", 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_all("release_no_edge", 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    @(posedge clk); #1;
    chk_all("release_first", 0, 8'h33, 5'h13, 5'h00, 5'h00, 5'h00);
    @(posedge clk); #1;
    chk_all("release_second", 0, 8'h66, 5'h06, 5'h00, 5'h00, 5'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
